mac_result_collector: RTL

//   Downstream consumer of the 4-tap 8x8 MAC neuron stage. Receives the MAC's 18-bit dot product as two

---
 rtl/mac_result_collector_pkg.sv | 28 ++
 rtl/mac_result_collector_sync_fifo.sv | 73 +++++++
 rtl/mac_result_collector.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mac_result_collector_pkg.sv
// Shared types and constants for the MAC result collector.
//   PH_HI/PH_LO  : phase tag carried in in_word[9]
//   asm_state_t  : half-word assembly FSM states
//   half_word_t  : {phase, half} payload as delivered by the MAC stage
package mac_result_collector_pkg;

    localparam int unsigned RES_W  = 18;
    localparam int unsigned HALF_W = RES_W / 2;
    localparam int unsigned ACT_W  = 8;
    localparam int unsigned DROP_W = 8;

    localparam logic [ACT_W-1:0]  ACT_MAX  = 8'hFF;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    localparam logic PH_HI = 1'b0;
    localparam logic PH_LO = 1'b1;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    typedef struct packed {
        logic              phase;
        logic [HALF_W-1:0] half;
    } half_word_t;

endpackage

// File: rtl/mac_result_collector_sync_fifo.sv
// Synchronous FIFO with a registered head: out_valid and out_data are flops.
//   push/wdata : write request; accepted when not full or when a pop occurs the same cycle
//   pop        : consume head; ignored while empty
//   full_c     : combinational full flag from the registered pointers
//   out_valid  : FIFO non-empty
//   out_data   : head entry, 0 when empty
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full_c,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [WIDTH-1:0] head_d;
    logic             valid_d;
    logic             do_push, do_pop;

    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & out_valid;
    assign do_push = push & (~full_c | do_pop);

    // Next pointers and next head; the head bypasses from wdata when the
    // entry being written this cycle becomes the new head.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        valid_d  = (rd_ptr_d != wr_ptr_d);
        head_d   = '0;
        if (valid_d) begin
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wdata;
            end else begin
                head_d = mem[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_valid <= valid_d;
            out_data  <= head_d;
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Reassembles 18-bit MAC results from tagged 9-bit halves, adds bias, applies
// ReLU, shift and 8-bit saturation, and buffers activations in a FIFO.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_word  : half-word strobe and {phase, half}
//   cfg_bias, cfg_shift: signed bias and right-shift, sampled with the low half
//   out_valid/out_ready/out_data : activation stream
//   err_seq            : one-cycle pulse per out-of-order half-word
//   drop_count         : saturating count of results lost to a full FIFO
module mac_result_collector
    import mac_result_collector_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BIAS_W     = 8,
    parameter int unsigned SHIFT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [HALF_W:0]    in_word,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACT_W-1:0]   out_data,
    output logic               err_seq,
    output logic [DROP_W-1:0]  drop_count
);

    // Two bits of headroom: max result plus max positive bias exceeds 19-bit signed.
    localparam int unsigned SUM_W = RES_W + 2;

    half_word_t          word;
    asm_state_t          state_q, state_d;
    logic [HALF_W-1:0]   hi_q, hi_d;
    logic                done_c, err_c;

    logic [RES_W-1:0]        res_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [SUM_W-2:0]        relu_c, shf_c;
    logic [ACT_W-1:0]        act_c;

    logic                push_q;
    logic [ACT_W-1:0]    act_q;
    logic                fifo_full_c;
    logic                drop_c;

    assign word = half_word_t'(in_word);

    // Assembly FSM next-state logic.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        done_c  = 1'b0;
        err_c   = 1'b0;
        if (in_valid) begin
            case (state_q)
                WAIT_HI: begin
                    if (word.phase == PH_HI) begin
                        hi_d    = word.half;
                        state_d = WAIT_LO;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (word.phase == PH_LO) begin
                        done_c  = 1'b1;
                        state_d = WAIT_HI;
                    end else begin
                        hi_d  = word.half;
                        err_c = 1'b1;
                    end
                end
                default: state_d = WAIT_HI;
            endcase
        end
    end

    // Assembly FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_HI;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    // Activation datapath on the half being accepted now.
    always_comb begin
        res_c  = {hi_q, word.half};
        sum_c  = $signed({2'b00, res_c}) + SUM_W'($signed(cfg_bias));
        relu_c = sum_c[SUM_W-1] ? '0 : sum_c[SUM_W-2:0];
        shf_c  = relu_c >> cfg_shift;
        act_c  = (|shf_c[SUM_W-2:ACT_W]) ? ACT_MAX : shf_c[ACT_W-1:0];
    end

    // One pipeline stage between assembly and FIFO write, plus status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_q     <= 1'b0;
            act_q      <= '0;
            err_seq    <= 1'b0;
            drop_count <= '0;
        end else begin
            push_q  <= done_c;
            err_seq <= err_c;
            if (done_c) begin
                act_q <= act_c;
            end
            if (drop_c && (drop_count != DROP_MAX)) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    // A full FIFO still takes the push when its head leaves the same cycle.
    assign drop_c = push_q & fifo_full_c & ~out_ready;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ACT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .wdata     (act_q),
        .pop       (out_ready),
        .full_c    (fifo_full_c),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule
